// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect/halt controls and decoder handshake.
`timescale 1ns/1ps
interface instruction_fetch_unit_if #(
   parameter int unsigned byte_W = 4,
   parameter int unsigned Addr_W = 8
);
   localparam int unsigned INSTR_W = 8 * byte_W;

   logic [Addr_W-1:0]  imem_address;
   logic [INSTR_W-1:0] imem_data;
   logic               branch_taken;
   logic [Addr_W-1:0]  branch_target;
   logic               halt;
   logic               out_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instruction;
   logic [Addr_W-1:0]  out_pc;
   logic [Addr_W-1:0]  out_pc_next;
   logic               out_halted;
   logic [15:0]        out_fetch_count;

   // Fetch unit side
   modport master (
      output imem_address,
      input  imem_data,
      input  branch_taken,
      input  branch_target,
      input  halt,
      input  out_ready,
      output out_valid,
      output out_instruction,
      output out_pc,
      output out_pc_next,
      output out_halted,
      output out_fetch_count
   );

   // Memory / decoder / control side
   modport slave (
      input  imem_address,
      output imem_data,
      output branch_taken,
      output branch_target,
      output halt,
      output out_ready,
      input  out_valid,
      input  out_instruction,
      input  out_pc,
      input  out_pc_next,
      input  out_halted,
      input  out_fetch_count
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the memory word into a
// valid/ready output register, supports branch redirect with flush and halt.
`timescale 1ns/1ps
module instruction_fetch_unit #(
   parameter int unsigned      byte_W   = 4,
   parameter int unsigned      Addr_W   = 8,
   parameter logic [Addr_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   instruction_fetch_unit_if.master bus
);
   localparam int unsigned INSTR_W    = 8 * byte_W;
   localparam int unsigned CNT_W      = 16;
   localparam logic [Addr_W-1:0] PC_STEP    = Addr_W'(byte_W);
   localparam logic [Addr_W-1:0] ALIGN_MASK = ~Addr_W'(byte_W - 1);

   typedef enum logic {RUN, HALTED} state_t;

   state_t               state_q, state_d;
   logic [Addr_W-1:0]    pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [Addr_W-1:0]    opc_q, opc_d;
   logic [Addr_W-1:0]    opcn_q, opcn_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [Addr_W-1:0]    pc_step;
   logic                 xfer;
   logic                 free;

   // Next-state and datapath decisions, highest-priority rule first
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      opcn_d  = opcn_q;
      cnt_d   = cnt_q;
      pc_step = pc_q + PC_STEP;
      xfer    = valid_q && bus.out_ready;
      free    = !valid_q || bus.out_ready;

      case (state_q)
         RUN: begin
            if (bus.halt) begin
               // Stop fetching; a pending entry drains but nothing new is captured
               state_d = HALTED;
               if (xfer) valid_d = 1'b0;
            end else if (bus.branch_taken) begin
               // Redirect to the aligned target and flush the output entry
               pc_d    = bus.branch_target & ALIGN_MASK;
               valid_d = 1'b0;
            end else if (free) begin
               instr_d = bus.imem_data;
               opc_d   = pc_q;
               opcn_d  = pc_step;
               valid_d = 1'b1;
               pc_d    = pc_step;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HALTED: begin
            if (xfer) valid_d = 1'b0;
         end
         default: state_d = RUN;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
         opcn_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         opcn_q  <= opcn_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.imem_address    = pc_q;
   assign bus.out_valid       = valid_q;
   assign bus.out_instruction = instr_q;
   assign bus.out_pc          = opc_q;
   assign bus.out_pc_next     = opcn_q;
   assign bus.out_halted      = (state_q == HALTED);
   assign bus.out_fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan steps plus random traffic,
// every cycle compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
   localparam int unsigned BW = 4;
   localparam int unsigned AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset0;
   logic reset1;

   instruction_fetch_unit_if #(.byte_W(BW), .Addr_W(AW)) bus0 ();
   instruction_fetch_unit_if #(.byte_W(BW), .Addr_W(AW)) bus1 ();

   instruction_fetch_unit #(.byte_W(BW), .Addr_W(AW), .RESET_PC(8'h00)) dut0 (
      .clk(clk), .reset(reset0), .bus(bus0));
   instruction_fetch_unit #(.byte_W(BW), .Addr_W(AW), .RESET_PC(8'hFC)) dut1 (
      .clk(clk), .reset(reset1), .bus(bus1));

   // Byte-addressed little-endian instruction memory shared by both instances
   logic [7:0] mem [256];

   function automatic logic [31:0] rd(input logic [7:0] a);
      return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
   endfunction

   always_comb bus0.imem_data = rd(bus0.imem_address);
   always_comb bus1.imem_data = rd(bus1.imem_address);

   task automatic put_word(input logic [7:0] a, input logic [31:0] w);
      mem[a]        = w[7:0];
      mem[a + 8'd1] = w[15:8];
      mem[a + 8'd2] = w[23:16];
      mem[a + 8'd3] = w[31:24];
   endtask

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the fetch stage viewed as a PC plus one output slot
   logic [7:0]  m_pc, m_opc, m_opcn;
   logic [31:0] m_instr;
   logic        m_valid, m_halted;
   logic [15:0] m_cnt;

   task automatic model_step();
      if (reset0) begin
         m_pc = 8'h00; m_valid = 1'b0; m_instr = '0; m_opc = '0; m_opcn = '0;
         m_cnt = '0; m_halted = 1'b0;
      end else if (m_halted || bus0.halt) begin
         m_halted = 1'b1;
         if (m_valid && bus0.out_ready) m_valid = 1'b0;
      end else if (bus0.branch_taken) begin
         m_pc    = bus0.branch_target & 8'hFC;
         m_valid = 1'b0;
      end else if (!m_valid || bus0.out_ready) begin
         m_instr = rd(m_pc);
         m_opc   = m_pc;
         m_opcn  = m_pc + 8'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 8'd4;
         m_cnt   = m_cnt + 16'd1;
      end
   endtask

   task automatic compare_model();
      chk("imem_address", 32'(bus0.imem_address), 32'(m_pc));
      chk("out_valid", 32'(bus0.out_valid), 32'(m_valid));
      chk("out_halted", 32'(bus0.out_halted), 32'(m_halted));
      chk("out_fetch_count", 32'(bus0.out_fetch_count), 32'(m_cnt));
      if (m_valid) begin
         chk("out_instruction", bus0.out_instruction, m_instr);
         chk("out_pc", 32'(bus0.out_pc), 32'(m_opc));
         chk("out_pc_next", 32'(bus0.out_pc_next), 32'(m_opcn));
      end
   endtask

   // One clock: model consumes the pre-edge inputs, outputs checked after the edge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic set_in(input logic rdy, input logic br, input logic [7:0] tgt, input logic h);
      bus0.out_ready     = rdy;
      bus0.branch_taken  = br;
      bus0.branch_target = tgt;
      bus0.halt          = h;
   endtask

   logic [31:0] plan_words [4];

   initial begin
      plan_words[0] = 32'h04121000;
      plan_words[1] = 32'h04123004;
      plan_words[2] = 32'h00832101;
      plan_words[3] = 32'h18000000;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) put_word(8'(4 * i), plan_words[i]);
      put_word(8'hFC, 32'hA5C3_0F17);

      reset0 = 1'b1;
      reset1 = 1'b1;
      set_in(1'b1, 1'b0, 8'h00, 1'b0);
      bus1.out_ready = 1'b1; bus1.branch_taken = 1'b0; bus1.branch_target = '0; bus1.halt = 1'b0;

      // Reset state
      tick();
      chk("rst_imem_address", 32'(bus0.imem_address), 32'h00);
      chk("rst_out_valid", 32'(bus0.out_valid), 32'h0);
      chk("rst_out_fetch_count", 32'(bus0.out_fetch_count), 32'h0);
      reset0 = 1'b0;

      // Straight-line fetch, one per cycle
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("seq_instruction", bus0.out_instruction, plan_words[i]);
         chk("seq_pc", 32'(bus0.out_pc), 32'(4 * i));
         chk("seq_count", 32'(bus0.out_fetch_count), 32'(i + 1));
      end

      // Backpressure while out_pc = 4
      reset0 = 1'b1; tick(); reset0 = 1'b0;
      tick(); tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_instruction", bus0.out_instruction, 32'h04123004);
         chk("stall_imem_address", 32'(bus0.imem_address), 32'h08);
      end
      set_in(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("release_pc", 32'(bus0.out_pc), 32'h08);

      // Branch with flush while the pc-4 entry is stalled
      reset0 = 1'b1; tick(); reset0 = 1'b0;
      tick(); tick();
      set_in(1'b0, 1'b1, 8'h0E, 1'b0);
      tick();
      chk("branch_flush_valid", 32'(bus0.out_valid), 32'h0);
      chk("branch_imem_address", 32'(bus0.imem_address), 32'h0C);
      set_in(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("branch_target_valid", 32'(bus0.out_valid), 32'h1);
      chk("branch_target_pc", 32'(bus0.out_pc), 32'h0C);
      chk("branch_target_instr", bus0.out_instruction, 32'h18000000);

      // Branch and halt together with a pending entry
      set_in(1'b0, 1'b1, 8'h40, 1'b1);
      tick();
      chk("halt_flag", 32'(bus0.out_halted), 32'h1);
      chk("halt_pc_held", 32'(bus0.imem_address), 32'h10);
      chk("halt_entry_kept", 32'(bus0.out_valid), 32'h1);
      set_in(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("halt_drained", 32'(bus0.out_valid), 32'h0);
      for (int i = 0; i < 4; i++) begin
         set_in(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
         tick();
         chk("halted_no_fetch", 32'(bus0.out_valid), 32'h0);
         chk("halted_pc", 32'(bus0.imem_address), 32'h10);
      end

      // Reset during a stall
      set_in(1'b1, 1'b0, 8'h00, 1'b0);
      reset0 = 1'b1; tick(); reset0 = 1'b0;
      tick(); tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      reset0 = 1'b1;
      tick();
      chk("rst_stall_valid", 32'(bus0.out_valid), 32'h0);
      chk("rst_stall_count", 32'(bus0.out_fetch_count), 32'h0);
      chk("rst_stall_imem_address", 32'(bus0.imem_address), 32'h00);
      reset0 = 1'b0;
      set_in(1'b1, 1'b0, 8'h00, 1'b0);

      // PC wrap on the instance reset to 0xFC
      tick();
      chk("wrap_rst_imem_address", 32'(bus1.imem_address), 32'hFC);
      reset1 = 1'b0;
      tick();
      chk("wrap_first_pc", 32'(bus1.out_pc), 32'hFC);
      chk("wrap_first_pc_next", 32'(bus1.out_pc_next), 32'h00);
      chk("wrap_first_instr", bus1.out_instruction, 32'hA5C30F17);
      tick();
      chk("wrap_second_pc", 32'(bus1.out_pc), 32'h00);
      chk("wrap_second_instr", bus1.out_instruction, 32'h04121000);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                8'($urandom), $urandom_range(0, 79) == 0);
         reset0 = (m_halted && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
